// File: rtl/multi_digit_counter_if.sv
// Bundle of the signals that run between the board switches/buttons, the
// multi-digit counter and the multiplexed seven-segment display.
//   master : board side, drives load/count_en/up/data_in/dp_in and
//            observes value/carry_out/an/seg
//   slave  : counter side
interface multi_digit_counter_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      load;
  logic                      count_en;
  logic                      up;
  logic [4*NUM_DIGITS-1:0]   data_in;
  logic [NUM_DIGITS-1:0]     dp_in;
  logic [4*NUM_DIGITS-1:0]   value;
  logic                      carry_out;
  logic [NUM_DIGITS-1:0]     an;
  logic [7:0]                seg;

  modport master (
    output load, count_en, up, data_in, dp_in,
    input  value, carry_out, an, seg
  );

  modport slave (
    input  load, count_en, up, data_in, dp_in,
    output value, carry_out, an, seg
  );
endinterface

// File: rtl/multi_digit_counter.sv
// Multi-digit up/down counter (hex or BCD) with parallel load, a count-rate
// divider and a time-multiplexed seven-segment display driver.
//   clk_in        : sole clock, rising edge
//   nReset        : synchronous active-low reset
//   bus.load      : load data_in into the count (beats counting)
//   bus.count_en  : count on a divider tick
//   bus.up        : 1 = count up, 0 = count down
//   bus.data_in   : load value, digit i at [4i+3:4i]
//   bus.dp_in     : decimal point request per digit
//   bus.value     : registered count, digit 0 least significant
//   bus.carry_out : one-cycle pulse after a full wrap in either direction
//   bus.an        : active-low one-hot digit enable
//   bus.seg       : active-low segments {dp,g,f,e,d,c,b,a}
module multi_digit_counter #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV_COUNT  = 50_000_000,
  parameter int SCAN_COUNT = 50_000,
  parameter int DECIMAL    = 0
) (
  input logic                  clk_in,
  input logic                  nReset,
  multi_digit_counter_if.slave bus
);

  localparam int TW = (DIV_COUNT  > 1) ? $clog2(DIV_COUNT)  : 1;
  localparam int SW = (SCAN_COUNT > 1) ? $clog2(SCAN_COUNT) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(DIV_COUNT - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_COUNT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [3:0]    DIGIT_MAX = (DECIMAL != 0) ? 4'd9 : 4'hF;

  logic [TW-1:0]             tick_cnt;
  logic [SW-1:0]             scan_cnt;
  logic [IW-1:0]             digit_idx;
  logic [4*NUM_DIGITS-1:0]   value_q;
  logic                      carry_q;
  logic [NUM_DIGITS-1:0]     an_q;
  logic [7:0]                seg_q;

  logic                      tick;
  logic [4*NUM_DIGITS-1:0]   load_val;
  logic [4*NUM_DIGITS-1:0]   step_val;
  logic                      wrap;
  logic [3:0]                cur_digit;
  logic                      cur_dp;
  logic [NUM_DIGITS-1:0]     an_next;

  // Active-low {g,f,e,d,c,b,a}; the dp bit is added separately.
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign tick = (tick_cnt == TICK_LAST);

  // In BCD mode a loaded nibble above 9 is clamped so the count never holds
  // an illegal digit.
  always_comb begin
    load_val = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((DECIMAL != 0) && (bus.data_in[4*i +: 4] > 4'd9))
        load_val[4*i +: 4] = 4'd9;
      else
        load_val[4*i +: 4] = bus.data_in[4*i +: 4];
    end
  end

  // Ripple carry/borrow through all digits in one cycle; wrap is the carry
  // (or borrow) leaving the top digit.
  always_comb begin
    logic       ripple;
    logic [3:0] d;
    step_val = value_q;
    ripple   = 1'b1;
    d        = 4'h0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d = value_q[4*i +: 4];
      if (ripple) begin
        if (bus.up) begin
          if (d == DIGIT_MAX) begin
            step_val[4*i +: 4] = 4'h0;
          end else begin
            step_val[4*i +: 4] = d + 4'd1;
            ripple = 1'b0;
          end
        end else begin
          if (d == 4'h0) begin
            step_val[4*i +: 4] = DIGIT_MAX;
          end else begin
            step_val[4*i +: 4] = d - 4'd1;
            ripple = 1'b0;
          end
        end
      end
    end
    wrap = ripple;
  end

  always_comb begin
    cur_digit = 4'h0;
    cur_dp    = 1'b0;
    an_next   = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx == IW'(i)) begin
        cur_digit  = value_q[4*i +: 4];
        cur_dp     = bus.dp_in[i];
        an_next[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!nReset) begin
      tick_cnt  <= '0;
      scan_cnt  <= '0;
      digit_idx <= '0;
      value_q   <= '0;
      carry_q   <= 1'b0;
      an_q      <= '1;
      seg_q     <= 8'hFF;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);

      if (scan_cnt == SCAN_LAST) begin
        scan_cnt  <= '0;
        digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + IW'(1);
      end else begin
        scan_cnt <= scan_cnt + SW'(1);
      end

      an_q  <= an_next;
      seg_q <= {~cur_dp, seg_of(cur_digit)};

      carry_q <= 1'b0;
      if (bus.load) begin
        value_q <= load_val;
      end else if (tick && bus.count_en) begin
        value_q <= step_val;
        carry_q <= wrap;
      end
    end
  end

  assign bus.value     = value_q;
  assign bus.carry_out = carry_q;
  assign bus.an        = an_q;
  assign bus.seg       = seg_q;

endmodule

// File: tb/tb_multi_digit_counter.sv
module tb_multi_digit_counter;

  typedef struct {
    int          k;
    logic [15:0] value;
    logic        carry;
    logic [3:0]  an;
    logic [7:0]  seg;
  } exp_t;

  // Three DUTs: hex (DIV=1,SCAN=1), BCD (DIV=1,SCAN=1), hex (DIV=4,SCAN=3)
  localparam int RADIX [3] = '{16, 10, 16};
  localparam int DIVC  [3] = '{1, 1, 4};
  localparam int SCANC [3] = '{1, 1, 3};
  localparam logic [7:0] SEG_TAB [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic        s_rst_n [3];
  logic        s_load  [3];
  logic        s_en    [3];
  logic        s_up    [3];
  logic [15:0] s_data  [3];
  logic [3:0]  s_dp    [3];

  multi_digit_counter_if #(.NUM_DIGITS(4)) bus_a ();
  multi_digit_counter_if #(.NUM_DIGITS(4)) bus_b ();
  multi_digit_counter_if #(.NUM_DIGITS(4)) bus_c ();

  assign bus_a.load = s_load[0];  assign bus_a.count_en = s_en[0];  assign bus_a.up = s_up[0];
  assign bus_a.data_in = s_data[0];  assign bus_a.dp_in = s_dp[0];
  assign bus_b.load = s_load[1];  assign bus_b.count_en = s_en[1];  assign bus_b.up = s_up[1];
  assign bus_b.data_in = s_data[1];  assign bus_b.dp_in = s_dp[1];
  assign bus_c.load = s_load[2];  assign bus_c.count_en = s_en[2];  assign bus_c.up = s_up[2];
  assign bus_c.data_in = s_data[2];  assign bus_c.dp_in = s_dp[2];

  multi_digit_counter #(.NUM_DIGITS(4), .DIV_COUNT(1), .SCAN_COUNT(1), .DECIMAL(0)) u_dut_a (
    .clk_in(clk_in), .nReset(s_rst_n[0]), .bus(bus_a));
  multi_digit_counter #(.NUM_DIGITS(4), .DIV_COUNT(1), .SCAN_COUNT(1), .DECIMAL(1)) u_dut_b (
    .clk_in(clk_in), .nReset(s_rst_n[1]), .bus(bus_b));
  multi_digit_counter #(.NUM_DIGITS(4), .DIV_COUNT(4), .SCAN_COUNT(3), .DECIMAL(0)) u_dut_c (
    .clk_in(clk_in), .nReset(s_rst_n[2]), .bus(bus_c));

  // Reference model: the count is a plain integer modulo radix^4.
  int   mv [3];
  int   mt [3];
  int   ms [3];
  int   mi [3];
  exp_t sb_q [$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic int rpow(input int r, input int e);
    int p = 1;
    for (int j = 0; j < e; j++) p = p * r;
    return p;
  endfunction

  function automatic logic [15:0] encode(input int v, input int r);
    logic [15:0] o = '0;
    for (int j = 0; j < 4; j++) o[4*j +: 4] = 4'((v / rpow(r, j)) % r);
    return o;
  endfunction

  function automatic int decode(input logic [15:0] d, input int r);
    int v = 0;
    int n;
    for (int j = 0; j < 4; j++) begin
      n = int'(d[4*j +: 4]);
      if (n > r - 1) n = r - 1;
      v = v + n * rpow(r, j);
    end
    return v;
  endfunction

  task automatic model_step(input int k);
    exp_t e;
    int   dig;
    int   full;
    bit   tk;
    e.k = k;
    if (!s_rst_n[k]) begin
      mv[k] = 0; mt[k] = 0; ms[k] = 0; mi[k] = 0;
      e.carry = 1'b0; e.an = 4'hF; e.seg = 8'hFF;
    end else begin
      full = rpow(RADIX[k], 4);
      dig  = (mv[k] / rpow(RADIX[k], mi[k])) % RADIX[k];
      e.an = 4'hF;
      e.an[mi[k]] = 1'b0;
      e.seg = SEG_TAB[dig];
      if (s_dp[k][mi[k]]) e.seg[7] = 1'b0;
      tk = (mt[k] == DIVC[k] - 1);
      mt[k] = tk ? 0 : mt[k] + 1;
      if (ms[k] == SCANC[k] - 1) begin
        ms[k] = 0;
        mi[k] = (mi[k] + 1) % 4;
      end else begin
        ms[k] = ms[k] + 1;
      end
      e.carry = 1'b0;
      if (s_load[k]) begin
        mv[k] = decode(s_data[k], RADIX[k]);
      end else if (tk && s_en[k]) begin
        if (s_up[k]) begin
          e.carry = (mv[k] == full - 1);
          mv[k] = (mv[k] + 1) % full;
        end else begin
          e.carry = (mv[k] == 0);
          mv[k] = (mv[k] + full - 1) % full;
        end
      end
    end
    e.value = encode(mv[k], RADIX[k]);
    sb_q.push_back(e);
  endtask

  // One clock edge for all DUTs: expectations are queued at the edge.
  task automatic cycle();
    @(posedge clk_in);
    for (int k = 0; k < 3; k++) model_step(k);
    #2;
  endtask

  task automatic do_load(input int k, input logic [15:0] d);
    s_load[k] = 1'b1;
    s_data[k] = d;
    cycle();
    s_load[k] = 1'b0;
  endtask

  task automatic do_count(input int k, input logic dir, input int n);
    s_en[k] = 1'b1;
    s_up[k] = dir;
    repeat (n) cycle();
    s_en[k] = 1'b0;
  endtask

  task automatic check_out(input int k, input logic [15:0] v, input logic c,
                           input logic [3:0] a, input logic [7:0] s, input string tag);
    logic [15:0] a_val;
    logic        a_car;
    logic [3:0]  a_an;
    logic [7:0]  a_seg;
    case (k)
      0: begin a_val = bus_a.value; a_car = bus_a.carry_out; a_an = bus_a.an; a_seg = bus_a.seg; end
      1: begin a_val = bus_b.value; a_car = bus_b.carry_out; a_an = bus_b.an; a_seg = bus_b.seg; end
      default: begin a_val = bus_c.value; a_car = bus_c.carry_out; a_an = bus_c.an; a_seg = bus_c.seg; end
    endcase
    n_checks++;
    if (a_val === v && a_car === c && a_an === a && a_seg === s) begin
      n_pass++;
    end else begin
      $display("FAIL %s dut%0d t=%0t: got value=%h carry=%b an=%b seg=%h, want value=%h carry=%b an=%b seg=%h",
               tag, k, $time, a_val, a_car, a_an, a_seg, v, c, a, s);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish in time");
    $finish;
  end

  // Monitor: outputs are registered and present every cycle.
  initial begin
    exp_t        e;
    logic [15:0] a_val;
    logic        a_car;
    logic [3:0]  a_an;
    logic [7:0]  a_seg;
    forever begin
      @(posedge clk_in);
      #1;
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        case (e.k)
          0: begin a_val = bus_a.value; a_car = bus_a.carry_out; a_an = bus_a.an; a_seg = bus_a.seg; end
          1: begin a_val = bus_b.value; a_car = bus_b.carry_out; a_an = bus_b.an; a_seg = bus_b.seg; end
          default: begin a_val = bus_c.value; a_car = bus_c.carry_out; a_an = bus_c.an; a_seg = bus_c.seg; end
        endcase
        n_checks++;
        if (a_val === e.value && a_car === e.carry && a_an === e.an && a_seg === e.seg) begin
          n_pass++;
        end else begin
          $display("FAIL dut%0d t=%0t: got value=%h carry=%b an=%b seg=%h, want value=%h carry=%b an=%b seg=%h",
                   e.k, $time, a_val, a_car, a_an, a_seg, e.value, e.carry, e.an, e.seg);
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      s_rst_n[k] = 1'b0; s_load[k] = 1'b0; s_en[k] = 1'b0;
      s_up[k] = 1'b1; s_data[k] = '0; s_dp[k] = '0;
      mv[k] = 0; mt[k] = 0; ms[k] = 0; mi[k] = 0;
    end
    // Reset held for two edges, with a load request that must lose.
    s_load[0] = 1'b1; s_data[0] = 16'h1234;
    cycle();
    cycle();
    for (int k = 0; k < 3; k++) check_out(k, 16'h0000, 1'b0, 4'hF, 8'hFF, "reset");
    s_load[0] = 1'b0;
    for (int k = 0; k < 3; k++) s_rst_n[k] = 1'b1;
    cycle();
    check_out(0, 16'h0000, 1'b0, 4'hE, 8'hC0, "release");

    // Hex: count up across digit boundaries, up wrap, down borrow/wrap.
    do_load(0, 16'h00FE);
    do_count(0, 1'b1, 3);
    do_load(0, 16'hFFFF);
    do_count(0, 1'b1, 1);
    cycle();
    do_load(0, 16'h0100);
    do_count(0, 1'b0, 2);
    do_load(0, 16'h0000);
    do_count(0, 1'b0, 1);
    cycle();
    // Scan with decimal point on digit 1.
    s_dp[0] = 4'b0010;
    do_load(0, 16'h1234);
    repeat (8) cycle();

    // BCD: clamp on load, decimal ripple, full wrap.
    do_load(1, 16'h0A99);
    do_count(1, 1'b1, 1);
    do_load(1, 16'h9999);
    do_count(1, 1'b1, 1);
    cycle();
    do_load(1, 16'h0000);
    do_count(1, 1'b0, 1);
    cycle();

    // Divided rate: load in the tick cycle wins, next step 4 cycles later.
    s_en[2] = 1'b1; s_up[2] = 1'b1;
    for (int j = 0; j < 8 && mt[2] != DIVC[2] - 1; j++) cycle();
    do_load(2, 16'h0500);
    repeat (10) cycle();
    // Direction changes between ticks have no effect until the tick.
    s_up[2] = 1'b0; cycle(); s_up[2] = 1'b1;
    repeat (6) cycle();
    s_en[2] = 1'b0;

    // Mid-operation reset of all DUTs.
    s_en[0] = 1'b1;
    for (int k = 0; k < 3; k++) s_rst_n[k] = 1'b0;
    cycle();
    for (int k = 0; k < 3; k++) s_rst_n[k] = 1'b1;
    repeat (6) cycle();

    // Randomized traffic on all DUTs together.
    repeat (400) begin
      for (int k = 0; k < 3; k++) begin
        s_rst_n[k] = ($urandom_range(0, 63) != 0);
        s_load[k]  = ($urandom_range(0, 7) == 0);
        s_en[k]    = ($urandom_range(0, 3) != 0);
        s_up[k]    = 1'($urandom_range(0, 1));
        s_dp[k]    = 4'($urandom);
        case ($urandom_range(0, 3))
          0: s_data[k] = 16'hFFFF;
          1: s_data[k] = 16'h0000;
          2: s_data[k] = 16'h9999;
          default: s_data[k] = 16'($urandom);
        endcase
      end
      cycle();
    end

    for (int k = 0; k < 3; k++) begin
      s_rst_n[k] = 1'b1; s_load[k] = 1'b0; s_en[k] = 1'b0;
    end
    cycle();
    cycle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    if (n_pass != n_checks) $display("FAIL");
    else $display("PASS");
    $finish;
  end

endmodule
